pam_multiport: RTL and testbench
================================

PAM_MULTIPORT -- requirements
Module: pam_multiport

Interface
REQ-001 Parameter DATA_W, 64, word width in bits; SHALL be a multiple of BYTE_W.
REQ-002 Parameter BYTE_W, 8, byte-enable granularity in bits.
REQ-003 Parameter DEPTH, 16, number of entries.
REQ-004 Parameter ADDR_W, 5, address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-005 Parameter NUM_RD, 3, number of read ports (1..8).
REQ-006 Parameter BYPASS, 1, 1 = write-first same-cycle forwarding, 0 = read-old.
REQ-007 clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 re  in  NUM_RD  per-port read enable.
REQ-010 raddr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 rdata  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-012 rvalid  out  NUM_RD  per-port flag: the returned entry holds written data.
REQ-013 we  in  1  write enable.
REQ-014 waddr  in  ADDR_W  write address.
REQ-015 wdata  in  DATA_W  write data.
REQ-016 be  in  DATA_W/BYTE_W  active-high byte enables.
REQ-017 clr_req  in  1  single-cycle request to start a clear sweep.
REQ-018 clr_busy  out  1  clear sweep in progress.
REQ-019 clr_done  out  1  one-cycle pulse when the sweep completes.
REQ-020 err  out  1  one-cycle pulse on an out-of-range or dropped access.

Function
REQ-021 Read latency SHALL be 1 cycle: re[k] at edge N updates rdata[k]/rvalid[k] at edge N; outputs SHALL hold when re[k]=0.
REQ-022 Write SHALL update only bytes with be=1; all other bytes SHALL be retained.
REQ-023 Each entry SHALL have a valid bit, set by any accepted write with be != 0.
REQ-024 Reading an entry whose valid bit is 0 SHALL return rdata=0 and rvalid=0.
REQ-025 Bytes never written since the last clear or reset SHALL read as 0 in a valid entry.
REQ-026 BYPASS=1: re[k] with raddr==waddr and an accepted write in the same cycle SHALL return the merged new word, with rvalid=1.
REQ-027 BYPASS=0: the same collision SHALL return the pre-write contents and pre-write valid bit.
REQ-028 All read ports SHALL be independent; any ports may read the same address in the same cycle.
REQ-029 A write with waddr >= DEPTH SHALL be ignored and SHALL pulse err the next cycle.
REQ-030 A read with raddr >= DEPTH SHALL return rdata=0, rvalid=0, and SHALL pulse err.
REQ-031 Clear FSM states: IDLE, SWEEP. IDLE->SWEEP on clr_req. In SWEEP, one entry per cycle (index 0..DEPTH-1) SHALL have its data zeroed and its valid bit cleared. SWEEP->IDLE after index DEPTH-1, pulsing clr_done in that same cycle.
REQ-032 clr_busy SHALL be 1 exactly while the FSM is in SWEEP.
REQ-033 clr_req while busy SHALL be ignored; no restart and no err.
REQ-034 Writes during SWEEP SHALL be dropped, with an err pulse.
REQ-035 Reads during SWEEP SHALL be served from current contents: swept entries return 0 with rvalid=0.
REQ-036 A clr_req and a we in the same IDLE cycle: the write SHALL be performed, then the sweep SHALL erase it.

Reset
REQ-037 rst SHALL clear all valid bits and set rdata=0, rvalid=0, clr_busy=0, clr_done=0, err=0, FSM=IDLE.
REQ-038 rst during SWEEP SHALL abort the sweep, with no clr_done pulse.
REQ-039 Data array contents SHALL not be reset; they are invisible while valid=0.

Structure
REQ-040 The FSM state encoding and the default parameter constants SHALL live in a shared package, pam_pkg.
REQ-041 Byte-mask expansion SHALL be one sub-module, pam_byte_mask (be -> DATA_W bit mask), reused by the write and bypass paths.

Verification
REQ-042 Write addr 3, wdata 0x1122334455667788, be=0xFF; next cycle read port0 addr 3 -> rdata=0x1122334455667788, rvalid=1.
REQ-043 After REQ-042, write addr 3, wdata 0xAAAA..AA, be=0x0F -> read returns 0x11223344AAAAAAAA.
REQ-044 BYPASS=1: write addr 5 = 0xDEAD, be=0x03, with ports 0/1/2 all reading addr 5 in the same cycle -> all ports return 0xDEAD, rvalid=1; with BYPASS=0 -> 0, rvalid=0.
REQ-045 DEPTH=16: write to addr 20 -> err pulse, no entry changed; read of addr 20 -> 0, rvalid=0, err pulse.
REQ-046 Fill all 16 entries, then clr_req -> clr_busy high for 16 cycles, clr_done in the 16th, writes during the sweep raise err, and all reads afterwards return 0 with rvalid=0.
REQ-047 clr_req, then rst after 5 cycles -> clr_busy=0 with no clr_done; all reads -> rvalid=0.

Source files
------------

// File: rtl/pam_pkg.sv
// Shared definitions for the multi-port pattern memory.
// Holds the default parameter constants and the clear-sweep FSM encoding.
package pam_pkg;

  localparam int unsigned DataWDefault  = 64;
  localparam int unsigned ByteWDefault  = 8;
  localparam int unsigned DepthDefault  = 16;
  localparam int unsigned AddrWDefault  = 5;
  localparam int unsigned NumRdDefault  = 3;
  localparam bit          BypassDefault = 1'b1;

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } clr_state_e;

endpackage

// File: rtl/pam_byte_mask.sv
// Expands per-byte enables into a per-bit mask.
// Ports:
//   be   - active-high byte enables, one per BYTE_W-bit lane
//   mask - DATA_W-bit mask, each lane replicated from its byte enable
module pam_byte_mask #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BYTE_W = 8
) (
  input  logic [DATA_W/BYTE_W-1:0] be,
  output logic [DATA_W-1:0]        mask
);

  for (genvar i = 0; i < DATA_W / BYTE_W; i++) begin : g_byte
    assign mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
  end

endmodule

// File: rtl/pam_multiport.sv
// Multi-read-port, single-write-port memory with per-entry valid bits,
// byte-enabled writes, optional write-first forwarding and a clear sweep.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   re, raddr         - per-port read enable and packed read addresses
//   rdata, rvalid     - per-port read data and "entry holds written data" flag
//   we, waddr, wdata  - write request
//   be                - write byte enables
//   clr_req           - start a clear sweep (ignored while one is running)
//   clr_busy          - sweep in progress
//   clr_done          - pulses in the last sweep cycle
//   err               - pulses after an out-of-range or dropped access
module pam_multiport
  import pam_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned BYTE_W = ByteWDefault,
  parameter int unsigned DEPTH  = DepthDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned NUM_RD = NumRdDefault,
  parameter bit          BYPASS = BypassDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  // Data array is deliberately not reset; the valid bits hide stale contents.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  clr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              sweep_last;

  logic              w_in_range, w_accept, w_set;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] bit_mask, w_old, w_merged;
  logic [NUM_RD-1:0] r_oob;
  logic              err_d, err_q;

  // ---------------- write path ----------------
  pam_byte_mask #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_byte_mask (
    .be   (be),
    .mask (bit_mask)
  );

  assign w_in_range = {1'b0, waddr} < DEPTH_A;
  assign w_idx      = waddr[IDX_W-1:0];
  assign w_accept   = we && w_in_range && (state_q == StIdle);
  assign w_set      = w_accept && (be != '0);
  // An invalid entry merges against zero so unwritten bytes read back as 0.
  assign w_old      = vld_q[w_idx] ? mem[w_idx] : '0;
  assign w_merged   = (w_old & ~bit_mask) | (wdata & bit_mask);

  always_ff @(posedge clk) begin
    if (w_set) begin
      mem[w_idx] <= w_merged;
    end else if (clr_busy) begin
      mem[idx_q] <= '0;
    end
  end

  // ---------------- clear FSM ----------------
  assign sweep_last = (idx_q == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (sweep_last) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr_busy = (state_q == StSweep);
    clr_done = (state_q == StSweep) && sweep_last;
  end

  // ---------------- valid bits and error pulse ----------------
  // Writes are dropped while sweeping, so set and clear never collide.
  assign err_d = (|r_oob) || (we && (!w_in_range || (state_q == StSweep)));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (w_set) begin
        vld_q[w_idx] <= 1'b1;
      end
      if (clr_busy) begin
        vld_q[idx_q] <= 1'b0;
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [IDX_W-1:0]  ri;
    logic              r_in_range, hit;
    logic [DATA_W-1:0] rd_d, rd_q;
    logic              rv_d, rv_q;

    assign ra         = raddr[k*ADDR_W +: ADDR_W];
    assign ri         = ra[IDX_W-1:0];
    assign r_in_range = {1'b0, ra} < DEPTH_A;
    assign r_oob[k]   = re[k] && !r_in_range;
    assign hit        = BYPASS && w_set && (ra == waddr);

    always_comb begin
      rd_d = '0;
      rv_d = 1'b0;
      if (r_in_range) begin
        if (hit) begin
          rd_d = w_merged;
          rv_d = 1'b1;
        end else if (vld_q[ri]) begin
          rd_d = mem[ri];
          rv_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else if (re[k]) begin
        rd_q <= rd_d;
        rv_q <= rv_d;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd_q;
    assign rvalid[k]                 = rv_q;
  end

endmodule

// File: tb/tb_pam_multiport.sv
// Scoreboard bench for pam_multiport: two instances (forwarding on and off)
// share all inputs; the driver queues expected read results and err values,
// and a monitor pops and compares them after each clock edge.
module tb_pam_multiport;

  logic         clk;
  logic         rst;
  logic [2:0]   re;
  logic [14:0]  raddr;
  logic [191:0] rdata1, rdata0;
  logic [2:0]   rvalid1, rvalid0;
  logic         we;
  logic [4:0]   waddr;
  logic [63:0]  wdata;
  logic [7:0]   be;
  logic         clr_req;
  logic         clr_busy1, clr_busy0, clr_done1, clr_done0, err1, err0;

  typedef struct {
    int          port;
    logic [63:0] d1;
    logic        v1;
    logic [63:0] d0;
    logic        v0;
  } rexp_t;

  rexp_t rq[$];
  logic  eq[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  pam_multiport #(.BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
    .we(we), .waddr(waddr), .wdata(wdata), .be(be), .clr_req(clr_req),
    .clr_busy(clr_busy1), .clr_done(clr_done1), .err(err1)
  );

  pam_multiport #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0),
    .we(we), .waddr(waddr), .wdata(wdata), .be(be), .clr_req(clr_req),
    .clr_busy(clr_busy0), .clr_done(clr_done0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One stimulus cycle; reads for the cycle are added with rd/rds afterwards.
  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [7:0] b, input logic c, input logic exp_err);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; be = b; clr_req = c;
    re = '0; raddr = '0;
    eq.push_back(exp_err);
  endtask

  // Call in ascending port order within a cycle.
  task automatic rd(input int k, input logic [4:0] a, input logic [63:0] d1, input logic v1,
                    input logic [63:0] d0, input logic v0);
    rexp_t e;
    re[k] = 1'b1;
    raddr[k*5 +: 5] = a;
    e.port = k; e.d1 = d1; e.v1 = v1; e.d0 = d0; e.v0 = v0;
    rq.push_back(e);
  endtask

  task automatic rds(input int k, input logic [4:0] a, input logic [63:0] d, input logic v);
    rd(k, a, d, v, d, v);
  endtask

  task automatic nop(input logic exp_err);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b0, exp_err);
  endtask

  // Monitor: compares queued expectations with what the DUTs present.
  initial begin
    logic [2:0] snap;
    logic       have_e, ee;
    rexp_t      e;
    forever begin
      @(posedge clk);
      snap   = re;
      have_e = (eq.size() > 0);
      if (have_e) ee = eq.pop_front();
      #1;
      if (have_e) begin
        chk("err_bypass1", 64'(err1), 64'(ee));
        chk("err_bypass0", 64'(err0), 64'(ee));
      end
      for (int k = 0; k < 3; k++) begin
        if (snap[k]) begin
          if (rq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_queue port %0d: got read with no expectation queued", k);
          end else begin
            e = rq.pop_front();
            chk("rd_port_order", 64'(k), 64'(e.port));
            chk("rdata_bypass1", rdata1[k*64 +: 64], e.d1);
            chk("rvalid_bypass1", 64'(rvalid1[k]), 64'(e.v1));
            chk("rdata_bypass0", rdata0[k*64 +: 64], e.d0);
            chk("rvalid_bypass0", 64'(rvalid0[k]), 64'(e.v0));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; re = '0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0; be = '0;
    clr_req = 1'b0;

    drive(1'b1, 1'b0, 5'd0, 64'd0, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 8'd0, 1'b0, 1'b0);

    // Reset state.
    nop(1'b0);
    chk("rst_rdata", rdata1[63:0] | rdata1[127:64] | rdata1[191:128], 64'd0);
    chk("rst_rvalid", 64'(rvalid1), 64'd0);
    chk("rst_clr_busy", 64'(clr_busy1), 64'd0);
    chk("rst_clr_done", 64'(clr_done1), 64'd0);

    // Unwritten entry reads as invalid on all ports.
    nop(1'b0);
    rds(0, 5'd3, 64'd0, 1'b0); rds(1, 5'd3, 64'd0, 1'b0); rds(2, 5'd3, 64'd0, 1'b0);

    // Full write then partial write.
    drive(1'b0, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0);
    nop(1'b0);
    rds(0, 5'd3, 64'h1122334455667788, 1'b1);
    drive(1'b0, 1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 1'b0);
    nop(1'b0);
    rds(1, 5'd3, 64'h11223344AAAAAAAA, 1'b1);

    // Same-cycle collision on all ports: forwarded vs pre-write contents.
    drive(1'b0, 1'b1, 5'd5, 64'h000000000000DEAD, 8'h03, 1'b0, 1'b0);
    rd(0, 5'd5, 64'hDEAD, 1'b1, 64'd0, 1'b0);
    rd(1, 5'd5, 64'hDEAD, 1'b1, 64'd0, 1'b0);
    rd(2, 5'd5, 64'hDEAD, 1'b1, 64'd0, 1'b0);
    nop(1'b0);
    rds(2, 5'd5, 64'hDEAD, 1'b1);

    // Out-of-range write is ignored and flagged; entry 4 must not alias it.
    drive(1'b0, 1'b1, 5'd20, 64'h5555555555555555, 8'hFF, 1'b0, 1'b1);
    rds(0, 5'd3, 64'h11223344AAAAAAAA, 1'b1);
    nop(1'b1);
    rds(0, 5'd20, 64'd0, 1'b0); rds(1, 5'd4, 64'd0, 1'b0); rds(2, 5'd31, 64'd0, 1'b0);
    nop(1'b0);

    // Single high byte into a fresh entry; other bytes read as zero.
    drive(1'b0, 1'b1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 8'h80, 1'b0, 1'b0);
    nop(1'b0);
    rds(2, 5'd7, 64'hFF00000000000000, 1'b1);
    // Outputs hold while re is low, even as the entry changes.
    drive(1'b0, 1'b1, 5'd7, 64'd0, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("hold_rdata", rdata1[128 +: 64], 64'hFF00000000000000);
    chk("hold_rvalid", 64'(rvalid1[2]), 64'd1);

    // Fill every entry.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 5'(i), 64'h100 + 64'(i), 8'hFF, 1'b0, 1'b0);
    end
    nop(1'b0);
    rds(0, 5'd0, 64'h100, 1'b1); rds(1, 5'd15, 64'h10F, 1'b1); rds(2, 5'd9, 64'h109, 1'b1);

    // Clear request together with a write; the sweep must erase it.
    drive(1'b0, 1'b1, 5'd2, 64'h77, 8'hFF, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      if (j == 3) drive(1'b0, 1'b1, 5'd1, 64'h99, 8'hFF, 1'b0, 1'b1);
      else if (j == 7) drive(1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b1, 1'b0);
      else nop(1'b0);
      chk("clr_busy_sweep", 64'(clr_busy1), 64'd1);
      chk("clr_done_sweep", 64'(clr_done1), (j == 15) ? 64'd1 : 64'd0);
      if (j == 5) begin
        rds(0, 5'd2, 64'd0, 1'b0);
        rds(1, 5'd12, 64'h10C, 1'b1);
      end
    end
    nop(1'b0);
    chk("clr_busy_after", 64'(clr_busy1), 64'd0);
    chk("clr_done_after", 64'(clr_done1), 64'd0);
    for (int i = 0; i < 6; i++) begin
      nop(1'b0);
      for (int k = 0; k < 3; k++) begin
        if (3 * i + k < 16) rds(k, 5'(3 * i + k), 64'd0, 1'b0);
      end
    end

    // Reset in the middle of a sweep aborts it without clr_done.
    drive(1'b0, 1'b1, 5'd1, 64'h1, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 5'd2, 64'h2, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 5'd10, 64'hA, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      nop(1'b0);
      chk("abort_busy", 64'(clr_busy1), 64'd1);
      chk("abort_done", 64'(clr_done1), 64'd0);
    end
    drive(1'b1, 1'b0, 5'd0, 64'd0, 8'd0, 1'b0, 1'b0);
    nop(1'b0);
    chk("abort_busy_rst", 64'(clr_busy1), 64'd0);
    chk("abort_done_rst", 64'(clr_done1), 64'd0);
    rds(0, 5'd1, 64'd0, 1'b0); rds(1, 5'd2, 64'd0, 1'b0); rds(2, 5'd10, 64'd0, 1'b0);

    nop(1'b0);
    nop(1'b0);
    @(posedge clk); #2;
    chk("rd_queue_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
